// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters and a saturating mispredict counter
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             predict,
  output logic [31:0]      predicted_addr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  output logic             hit,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int TAG_W = 32 - IDX_W - 2;
  logic             valid  [ENTRIES];
  logic [1:0]       ctr    [ENTRIES];
  logic [TAG_W-1:0] tag    [ENTRIES];
  logic [31:0]      target [ENTRIES];
  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;
  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};
  assign hit            = valid[if_idx] && tag[if_idx] == if_tag;
  assign predict        = hit && ctr[if_idx][1];
  assign predicted_addr = predict ? target[if_idx] : if_pc + 32'd4;
  assign upd_hit        = valid[upd_idx] && tag[upd_idx] == upd_tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= 2'b01;
      end
      mispredict_count <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr[upd_idx] <= upd_taken ? (ctr[upd_idx] == 2'b11 ? 2'b11 : ctr[upd_idx] + 2'd1)
                                  : (ctr[upd_idx] == 2'b00 ? 2'b00 : ctr[upd_idx] - 2'd1);
        if (upd_taken) target[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid[upd_idx]  <= 1'b1;
        tag[upd_idx]    <= upd_tag;
        target[upd_idx] <= upd_target;
        ctr[upd_idx]    <= 2'b10;
      end
      if (upd_mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_branch_target_buffer;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] if_pc = 0;
  logic        predict;
  logic [31:0] predicted_addr;
  logic        upd_valid = 0;
  logic [31:0] upd_pc = 0;
  logic        upd_taken = 0;
  logic [31:0] upd_target = 0;
  logic        upd_mispredict = 0;
  logic        hit;
  logic [15:0] mispredict_count;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .predict(predict), .predicted_addr(predicted_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .hit(hit), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        h;
    logic        p;
    logic [31:0] a;
    logic [15:0] c;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if ({hit, predict, predicted_addr, mispredict_count} !== {e.h, e.p, e.a, e.c}) begin
        n_fail++;
        $display("FAIL %s: got hit=%b predict=%b addr=%h cnt=%h, want hit=%b predict=%b addr=%h cnt=%h",
                 e.name, hit, predict, predicted_addr, mispredict_count, e.h, e.p, e.a, e.c);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic h, input logic p,
                            input logic [31:0] a, input logic [15:0] c);
    exp_t e;
    e.name = name; e.h = h; e.p = p; e.a = a; e.c = c;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mis);
    upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    step();
    upd_valid = 0; upd_mispredict = 0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic h, input logic p,
                      input logic [31:0] a, input logic [15:0] c);
    if_pc = pc;
    expect_out(name, h, p, a, c);
    step();
  endtask

  initial begin
    step();
    rst = 1; if_pc = 32'h100;
    step();
    rst = 0;
    look("reset_idle", 32'h100, 0, 0, 32'h104, 16'd0);
    look("pc_wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 16'd0);
    // allocate 0x100 -> 0x200, ctr=10
    train(32'h100, 1, 32'h200, 1);
    look("alloc_predict", 32'h100, 1, 1, 32'h200, 16'd1);
    train(32'h100, 1, 32'h200, 0);
    train(32'h100, 1, 32'h200, 0);
    look("ctr_sat_11", 32'h100, 1, 1, 32'h200, 16'd1);
    train(32'h100, 0, 32'hDEAD_0000, 0);
    look("ctr_10_target_kept", 32'h100, 1, 1, 32'h200, 16'd1);
    train(32'h100, 0, 32'hDEAD_0000, 0);
    look("ctr_01", 32'h100, 1, 0, 32'h104, 16'd1);
    repeat (3) train(32'h100, 0, 32'hDEAD_0000, 0);
    look("ctr_sat_00", 32'h100, 1, 0, 32'h104, 16'd1);
    train(32'h100, 1, 32'h250, 0);
    look("ctr_00_to_01", 32'h100, 1, 0, 32'h104, 16'd1);
    train(32'h100, 1, 32'h260, 0);
    look("ctr_10_new_target", 32'h100, 1, 1, 32'h260, 16'd1);
    // aliasing: 0x140 shares index 0 with 0x100
    look("alias_miss", 32'h140, 0, 0, 32'h144, 16'd1);
    train(32'h140, 1, 32'h300, 0);
    look("alias_replace_hit", 32'h140, 1, 1, 32'h300, 16'd1);
    look("alias_old_miss", 32'h100, 0, 0, 32'h104, 16'd1);
    train(32'h100, 0, 32'h999, 0);
    look("miss_nt_no_change", 32'h140, 1, 1, 32'h300, 16'd1);
    // same-cycle collision at 0x188
    if_pc = 32'h188;
    train(32'h188, 0, 32'h400, 0);
    look("miss_nt_stays_invalid", 32'h188, 0, 0, 32'h18C, 16'd1);
    upd_valid = 1; upd_pc = 32'h188; upd_taken = 1; upd_target = 32'h400; upd_mispredict = 0;
    expect_out("collision_pre_edge", 0, 0, 32'h18C, 16'd1);
    step();
    upd_valid = 0;
    look("collision_post_edge", 32'h188, 1, 1, 32'h400, 16'd1);
    look("low_bits_ignored", 32'h18B, 1, 1, 32'h400, 16'd1);
    upd_valid = 0; upd_mispredict = 1;
    step();
    upd_mispredict = 0;
    look("mis_without_valid", 32'h188, 1, 1, 32'h400, 16'd1);
    // mispredict flood on a non-allocating miss
    upd_valid = 1; upd_pc = 32'h800; upd_taken = 0; upd_mispredict = 1;
    repeat (65533) @(posedge clk);
    #1;
    expect_out("cnt_fffe", 1, 1, 32'h400, 16'hFFFE);
    step();
    expect_out("cnt_ffff", 1, 1, 32'h400, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    upd_valid = 0; upd_mispredict = 0;
    look("cnt_saturated", 32'h188, 1, 1, 32'h400, 16'hFFFF);
    // reset beats a simultaneous allocating update
    rst = 1;
    train(32'h188, 1, 32'h500, 1);
    rst = 0;
    look("rst_priority_188", 32'h188, 0, 0, 32'h18C, 16'd0);
    look("rst_priority_140", 32'h140, 0, 0, 32'h144, 16'd0);
    @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters, located in the IF stage of the RV32I pipeline. It produces the predicted-taken flag and predicted target for the fetch PC. These feed the EX-stage branch resolution/compare logic. It is trained one cycle-edge later from that logic's resolved outcome (taken flag, corrected target, mispredict flag). It also keeps a saturating mispredict counter for performance debug.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256
IDX_W, log2(ENTRIES) = 4, index width
CNT_W, 16, width of mispredict statistics counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset
if_pc  input  32  fetch-stage PC being looked up
predict  output  1  predicted taken for if_pc
predicted_addr  output  32  predicted next-fetch target for if_pc
upd_valid  input  1  EX stage holds a resolved branch/jump this cycle
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  actual branch outcome
upd_target  input  32  corrected target to store (resolver's updated predicted address)
upd_mispredict  input  1  resolver flagged redirect (final branch flag)
hit  output  1  if_pc matched a valid entry
mispredict_count  output  CNT_W  saturating count of mispredicts since reset

Behaviour:
- Reset: rst is synchronous, active-high. At a rising edge with rst=1, every valid bit is cleared, every counter is set to 2'b01 (weakly not-taken), and mispredict_count is set to 0. Targets and tags are don't-care. upd_* is ignored in that cycle.
- Because all valid bits are 0 after reset, the combinational outputs immediately give hit=0, predict=0, predicted_addr=if_pc+4.
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Lookup is purely combinational, with zero-cycle latency from if_pc:
  - hit = valid[idx] && tag[idx]==if_pc tag
  - predict = hit && ctr[idx][1]
  - predicted_addr = predict ? target[idx] : if_pc+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000)
- Training is synchronous, applied at the rising edge when upd_valid=1 and rst=0. Index and tag come from upd_pc.
  - Miss (entry invalid or tag differs) with upd_taken=1: allocate the entry. valid=1, tag written, target=upd_target, ctr=2'b10 (weakly taken). Any existing entry at that index is replaced.
  - Miss with upd_taken=0: no change to the entry.
  - Hit with upd_taken=1: ctr increments, saturating at 2'b11; target=upd_target.
  - Hit with upd_taken=0: ctr decrements, saturating at 2'b00; target is unchanged; valid stays 1.
- Counter FSM per entry: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11). Taken moves right and not-taken moves left, saturating at both ends.
- Read/write collision: if if_pc and upd_pc map to the same index in the same cycle, lookup returns the pre-edge contents. There is no bypass; the new state is visible from the next cycle.
- Mispredict counter: increments at the edge when upd_valid && upd_mispredict. It holds at 2^CNT_W-1 and never wraps. upd_mispredict with upd_valid=0 is ignored.
- Reset mid-training: if rst and upd_valid are both 1, reset wins and no allocation occurs.
- No X propagation: outputs are defined for every input once reset has been applied.

Test Plan:
1. Reset then idle: rst=1 for 1 cycle, if_pc=0x100 -> hit=0, predict=0, predicted_addr=0x104, mispredict_count=0.
2. Allocate and predict: upd_valid=1, upd_pc=0x100, upd_taken=1, upd_target=0x200, upd_mispredict=1, one edge. Then if_pc=0x100 -> hit=1, predict=1 (ctr=10), predicted_addr=0x200, mispredict_count=1.
3. Counter hysteresis: starting from scenario 2, train 0x100 taken twice -> ctr=11. Train not-taken once -> ctr=10, predict=1. Train not-taken again -> ctr=01, predict=0, predicted_addr=0x104, hit=1. Three more not-taken edges -> ctr holds at 00.
4. Aliasing/replacement: with 0x100 allocated, if_pc=0x140 (same index, different tag) -> hit=0, predicted_addr=0x144. Train 0x140 taken to 0x300 -> 0x140 hits with 0x300; 0x100 now misses.
5. Same-cycle collision: if_pc=upd_pc=0x180, entry invalid, upd_taken=1 -> predict=0 that cycle, predict=1 and predicted_addr=upd_target the next cycle. Not-taken on a miss -> entry stays invalid.
6. Saturation and reset priority: force 2^16+5 mispredicts -> mispredict_count=0xFFFF. Assert rst together with upd_valid=1 taken -> count=0, all entries miss.
